// File: rtl/aes_block_serial_arbiter.sv
// Round-robin arbiter that takes whole 128-bit blocks from two producers and
// streams each one out LSB byte first over a valid/ready byte interface.
module aes_block_serial_arbiter #(
    parameter int BYTE_GAP = 0
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    input  logic         byte_ready,
    output logic [3:0]   byte_idx,
    output logic         byte_src,
    output logic         byte_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(BYTE_GAP);

    state_t        state, state_next;
    logic [127:0]  buffer, buffer_next;
    logic [3:0]    idx, idx_next;
    logic          src, src_next;
    logic          last_grant, last_grant_next;
    logic [7:0]    gap_cnt, gap_cnt_next;
    logic          grant;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;

    assign byte_valid = (state == SEND);
    assign byte_data  = buffer[{idx, 3'b000} +: 8];
    assign byte_idx   = idx;
    assign byte_src   = src;
    assign byte_last  = byte_valid && (idx == 4'd15);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next      = state;
        buffer_next     = buffer;
        idx_next        = idx;
        src_next        = src;
        last_grant_next = last_grant;
        gap_cnt_next    = gap_cnt;

        case (state)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    buffer_next     = grant ? req1_data : req0_data;
                    src_next        = grant;
                    last_grant_next = grant;
                    idx_next        = 4'd0;
                    state_next      = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx == 4'd15) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 4'd1;
                        if (BYTE_GAP != 0) begin
                            gap_cnt_next = GAP_LOAD;
                            state_next   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) begin
                    state_next = SEND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            buffer     <= '0;
            idx        <= 4'd0;
            src        <= 1'b0;
            last_grant <= 1'b1;
            gap_cnt    <= 8'd0;
        end else begin
            state      <= state_next;
            buffer     <= buffer_next;
            idx        <= idx_next;
            src        <= src_next;
            last_grant <= last_grant_next;
            gap_cnt    <= gap_cnt_next;
        end
    end

endmodule

// File: tb/tb_aes_block_serial_arbiter.sv
// Directed bench for aes_block_serial_arbiter: an abstract block/byte model is
// compared every cycle, plus literal expectations for timing and ordering.
module tb_aes_block_serial_arbiter;

    localparam logic [127:0] BLK0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] BLKA = {16{8'hAA}};
    localparam logic [127:0] BLK5 = {16{8'h55}};

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         resetn, req0_valid, req1_valid, byte_ready;
    logic [127:0] req0_data, req1_data;
    logic         req0_ready, req1_ready, byte_valid, byte_src, byte_last, busy;
    logic [7:0]   byte_data;
    logic [3:0]   byte_idx;

    logic         g_resetn, g_req0_valid, g_req1_valid, g_byte_ready;
    logic [127:0] g_req0_data, g_req1_data;
    logic         g_req0_ready, g_req1_ready, g_byte_valid, g_byte_src, g_byte_last, g_busy;
    logic [7:0]   g_byte_data;
    logic [3:0]   g_byte_idx;

    aes_block_serial_arbiter #(.BYTE_GAP(0)) dut (
        .clock(clock), .resetn(resetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .byte_idx(byte_idx), .byte_src(byte_src), .byte_last(byte_last), .busy(busy)
    );

    aes_block_serial_arbiter #(.BYTE_GAP(2)) dut_gap (
        .clock(clock), .resetn(g_resetn),
        .req0_valid(g_req0_valid), .req0_data(g_req0_data), .req0_ready(g_req0_ready),
        .req1_valid(g_req1_valid), .req1_data(g_req1_data), .req1_ready(g_req1_ready),
        .byte_valid(g_byte_valid), .byte_data(g_byte_data), .byte_ready(g_byte_ready),
        .byte_idx(g_byte_idx), .byte_src(g_byte_src), .byte_last(g_byte_last), .busy(g_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit model_en = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    always @(posedge clock) cyc = cyc + 1;

    // Abstract model: either idle, or walking through a held block one byte at a time.
    bit           m_active = 1'b0;
    logic [127:0] m_block = '0;
    int           m_idx = 0;
    bit           m_src = 1'b0;
    bit           m_last_grant = 1'b1;

    function automatic int model_winner();
        if (req0_valid && req1_valid) return m_last_grant ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clock) begin
        int w;
        w = model_winner();
        if (!resetn) begin
            m_active = 1'b0; m_idx = 0; m_src = 1'b0; m_last_grant = 1'b1;
        end else if (m_active) begin
            if (byte_ready) begin
                if (m_idx == 15) m_active = 1'b0;
                else m_idx = m_idx + 1;
            end
        end else if (w >= 0) begin
            m_block = (w == 0) ? req0_data : req1_data;
            m_src = (w == 1);
            m_last_grant = (w == 1);
            m_idx = 0;
            m_active = 1'b1;
        end
    end

    always @(negedge clock) begin
        int w;
        if (model_en) begin
            w = m_active ? -1 : model_winner();
            checkOutput("req0_ready", 128'(req0_ready), 128'(w == 0));
            checkOutput("req1_ready", 128'(req1_ready), 128'(w == 1));
            checkOutput("byte_valid", 128'(byte_valid), 128'(m_active));
            checkOutput("busy", 128'(busy), 128'(m_active));
            if (m_active) begin
                checkOutput("byte_data", 128'(byte_data), 128'(8'(m_block >> (8 * m_idx))));
                checkOutput("byte_idx", 128'(byte_idx), 128'(m_idx));
                checkOutput("byte_src", 128'(byte_src), 128'(m_src));
                checkOutput("byte_last", 128'(byte_last), 128'(m_idx == 15));
            end else begin
                checkOutput("byte_last_idle", 128'(byte_last), 128'(0));
            end
        end
    end

    logic [7:0] got_data[$];
    logic [3:0] got_idx[$];
    bit         got_src[$];
    int         got_cyc[$];
    logic [7:0] last_data[$];
    bit         acc_src[$];
    int         acc_cyc[$];
    int         both_cnt, busy_cnt, hold_viol;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [3:0] prev_idx;

    always @(negedge clock) begin
        if (model_en) begin
            if (byte_valid && byte_ready) begin
                got_data.push_back(byte_data);
                got_idx.push_back(byte_idx);
                got_src.push_back(byte_src);
                got_cyc.push_back(cyc);
                if (byte_last) last_data.push_back(byte_data);
            end
            if (req0_valid && req0_ready) begin acc_src.push_back(1'b0); acc_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin acc_src.push_back(1'b1); acc_cyc.push_back(cyc); end
            if (req0_ready && req1_ready) both_cnt++;
            if (busy) busy_cnt++;
            if (prev_stall && (byte_data !== prev_data || byte_idx !== prev_idx)) hold_viol++;
            prev_stall = byte_valid && !byte_ready;
            prev_data = byte_data;
            prev_idx = byte_idx;
        end
    end

    logic [7:0] g_data[$];
    int         g_cyc[$];
    int         g_acc_cyc[$];
    int         g_busy_cnt;

    always @(negedge clock) begin
        if (g_resetn) begin
            if (g_byte_valid && g_byte_ready) begin g_data.push_back(g_byte_data); g_cyc.push_back(cyc); end
            if (g_req0_valid && g_req0_ready) g_acc_cyc.push_back(cyc);
            if (g_busy) g_busy_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [127:0] d0,
                                 input logic v1, input logic [127:0] d1, input logic br);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        byte_ready = br;
    endtask

    task automatic clearQueues();
        got_data.delete(); got_idx.delete(); got_src.delete(); got_cyc.delete();
        last_data.delete(); acc_src.delete(); acc_cyc.delete();
        both_cnt = 0; busy_cnt = 0; hold_viol = 0;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        clearQueues();
    endtask

    task automatic waitAccepts(input string name, input int n, input int bound);
        for (int k = 0; k < bound && acc_src.size() < n; k++) tick(1);
        checkOutput(name, 128'(acc_src.size()), 128'(n));
    endtask

    task automatic waitBytes(input string name, input int n, input int bound);
        for (int k = 0; k < bound && got_data.size() < n; k++) tick(1);
        checkOutput(name, 128'(got_data.size()), 128'(n));
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        g_resetn = 1'b0; g_req0_valid = 1'b0; g_req0_data = '0;
        g_req1_valid = 1'b0; g_req1_data = '0; g_byte_ready = 1'b1;
        clearQueues();
        tick(2);
        resetn = 1'b1;
        model_en = 1'b1;

        checkOutput("rst_byte_valid", 128'(byte_valid), 128'(0));
        checkOutput("rst_byte_data", 128'(byte_data), 128'(0));
        checkOutput("rst_byte_idx", 128'(byte_idx), 128'(0));
        checkOutput("rst_byte_src", 128'(byte_src), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));

        // Single block, downstream always ready.
        clearQueues();
        applyStimulus(1'b1, BLK0, 1'b0, '0, 1'b1);
        waitAccepts("t1_accept", 1, 20);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitBytes("t1_bytes", 16, 40);
        tick(3);
        checkOutput("t1_accept_count", 128'(acc_src.size()), 128'(1));
        checkOutput("t1_first_latency", 128'(got_cyc[0] - acc_cyc[0]), 128'(1));
        checkOutput("t1_span", 128'(got_cyc[15] - got_cyc[0]), 128'(15));
        for (int i = 0; i < 16; i++) begin
            checkOutput("t1_byte", 128'(got_data[i]), 128'(i));
            checkOutput("t1_src", 128'(got_src[i]), 128'(0));
        end
        checkOutput("t1_last_count", 128'(last_data.size()), 128'(1));
        checkOutput("t1_last_byte", 128'(last_data[0]), 128'(8'h0F));
        checkOutput("t1_busy_cycles", 128'(busy_cnt), 128'(16));

        // Both requesters hold valid: strict alternation with one bubble.
        doReset();
        applyStimulus(1'b1, BLKA, 1'b1, BLK5, 1'b1);
        waitAccepts("t2_accepts", 4, 200);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitBytes("t2_bytes", 64, 200);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_grant_order", 128'(acc_src[i]), 128'(i % 2));
            checkOutput("t2_block_byte", 128'(got_data[16 * i]), 128'((i % 2) ? 8'h55 : 8'hAA));
        end
        for (int i = 1; i < 4; i++)
            checkOutput("t2_block_period", 128'(acc_cyc[i] - acc_cyc[i - 1]), 128'(17));
        checkOutput("t2_both_ready", 128'(both_cnt), 128'(0));

        // Random backpressure on the byte stream.
        doReset();
        applyStimulus(1'b1, BLK0, 1'b0, '0, 1'b1);
        waitAccepts("t3_accept", 1, 20);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 300 && got_data.size() < 16; k++) begin
            byte_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        byte_ready = 1'b1;
        checkOutput("t3_bytes", 128'(got_data.size()), 128'(16));
        for (int i = 0; i < 16; i++) begin
            checkOutput("t3_byte", 128'(got_data[i]), 128'(i));
            checkOutput("t3_idx", 128'(got_idx[i]), 128'(i));
        end
        checkOutput("t3_hold_stable", 128'(hold_viol), 128'(0));

        // BYTE_GAP=2 instance: three-cycle byte spacing, 46-cycle block.
        g_resetn = 1'b0;
        tick(2);
        g_resetn = 1'b1;
        g_data.delete(); g_cyc.delete(); g_acc_cyc.delete(); g_busy_cnt = 0;
        g_req0_data = BLK0; g_req0_valid = 1'b1;
        for (int k = 0; k < 20 && g_acc_cyc.size() < 1; k++) tick(1);
        g_req0_valid = 1'b0;
        checkOutput("t4_accept", 128'(g_acc_cyc.size()), 128'(1));
        for (int k = 0; k < 100 && g_data.size() < 16; k++) tick(1);
        tick(4);
        checkOutput("t4_bytes", 128'(g_data.size()), 128'(16));
        checkOutput("t4_first_latency", 128'(g_cyc[0] - g_acc_cyc[0]), 128'(1));
        for (int i = 1; i < 16; i++)
            checkOutput("t4_spacing", 128'(g_cyc[i] - g_cyc[i - 1]), 128'(3));
        for (int i = 0; i < 16; i++)
            checkOutput("t4_byte", 128'(g_data[i]), 128'(i));
        checkOutput("t4_busy_cycles", 128'(g_busy_cnt), 128'(46));

        // Reset in the middle of a block, then a tie goes to requester 0.
        doReset();
        applyStimulus(1'b1, BLK0, 1'b0, '0, 1'b1);
        waitAccepts("t5_accept", 1, 20);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 40 && byte_idx !== 4'd7; k++) tick(1);
        checkOutput("t5_reached_idx7", 128'(byte_idx), 128'(7));
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        checkOutput("t5_valid_after_rst", 128'(byte_valid), 128'(0));
        checkOutput("t5_idx_after_rst", 128'(byte_idx), 128'(0));
        checkOutput("t5_busy_after_rst", 128'(busy), 128'(0));
        clearQueues();
        applyStimulus(1'b1, BLK0, 1'b1, BLK5, 1'b1);
        waitAccepts("t5_accept2", 1, 20);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitBytes("t5_bytes", 16, 40);
        checkOutput("t5_grant", 128'(acc_src[0]), 128'(0));
        checkOutput("t5_first_idx", 128'(got_idx[0]), 128'(0));
        checkOutput("t5_first_byte", 128'(got_data[0]), 128'(8'h00));
        checkOutput("t5_last_byte", 128'(got_data[15]), 128'(8'h0F));

        // Only requester 1: three blocks back to back.
        doReset();
        applyStimulus(1'b0, '0, 1'b1, BLK1, 1'b1);
        waitAccepts("t6_accepts", 3, 100);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitBytes("t6_bytes", 48, 100);
        for (int i = 1; i < 3; i++)
            checkOutput("t6_block_period", 128'(acc_cyc[i] - acc_cyc[i - 1]), 128'(17));
        for (int i = 0; i < 48; i++) begin
            checkOutput("t6_src", 128'(got_src[i]), 128'(1));
            checkOutput("t6_byte", 128'(got_data[i]), 128'(8'h10 + 8'(i % 16)));
        end
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
